// File: rtl/jk_driver.sv
// Command driver for an external JK flip-flop: issues one J/K excitation per command and checks Q two cycles later.
// Optional mismatch counter enabled by defining JK_DRIVER_ERRCNT_EN; otherwise err_cnt is tied to zero.
module jk_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             done,
    output logic             match,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t state;
    logic   exp_q;
    logic   mismatch;

    function automatic logic expected_q(input logic [1:0] c, input logic q);
        case (c)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // Returns {j, k} for a command.
    function automatic logic [1:0] excitation(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE) && !reset;
    assign mismatch  = (state == CHECK) && (q_fb != exp_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
            done  <= 1'b0;
            match <= 1'b0;
            exp_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        exp_q    <= expected_q(cmd, q_fb);
                        {j, k}   <= excitation(cmd);
                        state    <= DRIVE;
                    end
                end
                // Flip-flop samples J/K at the end of this cycle.
                DRIVE: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= CHECK;
                end
                CHECK: begin
                    done  <= 1'b1;
                    match <= (q_fb == exp_q);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A mismatch on the same edge as err_clr takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

`ifdef JK_DRIVER_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (mismatch) begin
            err_cnt_q <= err_clr ? CNT_W'(1) : sat_inc(err_cnt_q);
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_driver.sv
// Self-checking bench for jk_driver: vector table, directed corner sequences and a randomized run against a cycle-count model.
module tb_jk_driver;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;
`ifdef JK_DRIVER_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic             cmd_ready;
    logic             j, k;
    logic             q_fb;
    logic             done, match, err;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    // External JK flip-flop model with a load port and a stuck-at fault on its output.
    logic q_ff = 1'b0;
    logic ff_load = 1'b0, ff_load_val = 1'b0;
    logic stuck_en = 1'b0, stuck_val = 1'b0;
    assign q_fb = stuck_en ? stuck_val : q_ff;

    always @(posedge clk) begin
        if (ff_load) q_ff <= ff_load_val;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    always #5 clk = ~clk;

    jk_driver #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .j(j), .k(k), .q_fb(q_fb), .done(done), .match(match), .err(err),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
        return CNT_EN ? n : 0;
    endfunction

    task automatic load_q(input logic v);
        ff_load = 1'b1;
        ff_load_val = v;
        @(negedge clk);
        ff_load = 1'b0;
    endtask

    // Issues one command from a negedge; returns at the negedge where done should be high.
    task automatic do_cmd(input logic [1:0] c, input logic clr_at_check,
                          input logic ej, input logic ek, output logic m);
        int n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("drive_j", j, ej);
        chk("drive_k", k, ek);
        chk("drive_ready", cmd_ready, 0);
        @(negedge clk);
        chk("check_jk", {j, k}, 2'b00);
        chk("check_done", done, 0);
        if (clr_at_check) err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("done_pulse", done, 1);
        m = match;
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic       q_init;
        logic       exp_j;
        logic       exp_k;
        logic       exp_match;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic m;
        int   acc_e, ec;
        logic m_exp, m_done, m_match, m_err, m_j, m_k, m_ready, qv, mis;
        int   m_cnt;

        tbl[0] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1};  // SET from 0
        tbl[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b1};  // CLR from 1
        tbl[2] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1};  // HOLD at 1
        tbl[3] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1};  // TOGGLE from 1
        tbl[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1};  // HOLD at 0
        tbl[5] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b1};  // SET at 1

        // Reset held through 12 time units.
        reset = 1'b1;
        #10;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_jk", {j, k}, 2'b00);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_jk", {j, k}, 2'b00);
        chk("post_rst_done", done, 0);
        chk("post_rst_match", match, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_cnt", err_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            load_q(tbl[i].q_init);
            do_cmd(tbl[i].cmd, 1'b0, tbl[i].exp_j, tbl[i].exp_k, m);
            chk($sformatf("row%0d_match", i), m, tbl[i].exp_match);
            chk($sformatf("row%0d_err", i), err, 0);
        end

        // Four back-to-back toggles from q=0.
        load_q(1'b0);
        cmd_valid = 1'b1;
        cmd = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk($sformatf("tog_done_c%0d", n), done, (n % 3 == 0));
            chk($sformatf("tog_jk_c%0d", n), {j, k}, (n % 3 == 1) ? 2'b11 : 2'b00);
            if (n % 3 == 0) begin
                chk($sformatf("tog_match_c%0d", n), match, 1);
                chk($sformatf("tog_q_c%0d", n), q_fb, (n / 3) % 2);
            end
            if (n == 12) cmd_valid = 1'b0;
        end

        // Stuck-at-1 output under CLR.
        stuck_en = 1'b1;
        stuck_val = 1'b1;
        do_cmd(2'b01, 1'b0, 1'b0, 1'b1, m);
        chk("fault_match", m, 0);
        chk("fault_err", err, 1);
        chk("fault_cnt", err_cnt, exp_cnt(1));
        @(negedge clk);
        chk("fault_match_hold", match, 0);
        chk("fault_done_low", done, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_cnt", err_cnt, 0);

        // Mismatch coinciding with err_clr.
        do_cmd(2'b01, 1'b0, 1'b0, 1'b1, m);
        do_cmd(2'b01, 1'b1, 1'b0, 1'b1, m);
        chk("clr_race_err", err, 1);
        chk("clr_race_cnt", err_cnt, exp_cnt(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Counter saturation.
        for (int i = 1; i <= 5; i++) begin
            do_cmd(2'b01, 1'b0, 1'b0, 1'b1, m);
            chk($sformatf("sat_cnt_%0d", i), err_cnt, exp_cnt((i < CNT_MAX) ? i : CNT_MAX));
            chk($sformatf("sat_err_%0d", i), err, 1);
        end
        stuck_en = 1'b0;

        // Reset while driving.
        load_q(1'b0);
        cmd_valid = 1'b1;
        cmd = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_j_before", j, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_jk", {j, k}, 2'b00);
        chk("abort_ready", cmd_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_match", match, 0);
        chk("abort_err", err, 0);
        chk("abort_cnt", err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone_%0d", n), done, 0);
        end
        do_cmd(2'b00, 1'b0, 1'b0, 1'b0, m);
        chk("abort_hold_match", m, 1);

        // Randomized run against a cycle-count model.
        acc_e = -100; ec = 0;
        m_exp = 1'b0; m_done = 1'b1; m_match = 1'b1; m_err = 1'b0; m_cnt = 0;
        m_j = 1'b0; m_k = 1'b0;
        for (int it = 0; it < 400; it++) begin
            m_ready = (ec - acc_e >= 3);
            chk("rnd_ready", cmd_ready, m_ready);
            chk("rnd_jk", {j, k}, {m_j, m_k});
            chk("rnd_done", done, m_done);
            chk("rnd_match", match, m_match);
            chk("rnd_err", err, m_err);
            chk("rnd_cnt", err_cnt, exp_cnt(m_cnt));

            cmd_valid = 1'($urandom_range(0, 1));
            cmd = 2'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) stuck_en = ~stuck_en;
            stuck_val = 1'($urandom_range(0, 1));
            qv = stuck_en ? stuck_val : q_ff;

            m_done = 1'b0;
            m_j = 1'b0;
            m_k = 1'b0;
            mis = 1'b0;
            if (ec - acc_e == 2) begin
                m_done = 1'b1;
                m_match = (qv == m_exp);
                mis = (qv != m_exp);
            end
            if (mis) begin
                m_err = 1'b1;
                m_cnt = err_clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            end else if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            if (m_ready && cmd_valid) begin
                acc_e = ec;
                case (cmd)
                    2'b00: begin m_exp = qv;   m_j = 1'b0; m_k = 1'b0; end
                    2'b01: begin m_exp = 1'b0; m_j = 1'b0; m_k = 1'b1; end
                    2'b10: begin m_exp = 1'b1; m_j = 1'b1; m_k = 1'b0; end
                    default: begin m_exp = ~qv; m_j = 1'b1; m_k = 1'b1; end
                endcase
            end
            ec++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        err_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jk_driver.md
JK_DRIVER -- requirements
Module: jk_driver

Interface
REQ-001 The block SHALL take one parameter: CNT_W, default 8, width of the mismatch counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: the command is present.
REQ-005 The block SHALL have port cmd, input, 2 bits: 00 HOLD, 01 CLR, 10 SET, 11 TOGGLE.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-007 The block SHALL have ports j and k, outputs, 1 bit each: registered excitation to the external JK flip-flop.
REQ-008 The block SHALL have port q_fb, input, 1 bit: the Q output of the driven flip-flop.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a command completes.
REQ-010 The block SHALL have port match, output, 1 bit: the check result, valid while done=1.
REQ-011 The block SHALL have port err, output, 1 bit: a sticky mismatch flag.
REQ-012 The block SHALL have port err_clr, input, 1 bit: synchronous clear of err and err_cnt.
REQ-013 The block SHALL have port err_cnt, output, CNT_W bits: the count of mismatches.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, DRIVE and CHECK.
REQ-015 cmd_ready SHALL equal (state==IDLE) and SHALL be low while reset is asserted.
REQ-016 A command SHALL be accepted on the edge where cmd_valid=1 and cmd_ready=1; cmd_valid while not ready SHALL be ignored, with no buffering.
REQ-017 On accept, the block SHALL register the expected Q from the q_fb value sampled at that edge: HOLD gives q_fb, CLR gives 0, SET gives 1, TOGGLE gives ~q_fb.
REQ-018 On accept, the state SHALL go to DRIVE, and j,k SHALL be set from cmd: HOLD 0,0; CLR 0,1; SET 1,0; TOGGLE 1,1.
REQ-019 DRIVE SHALL last exactly one cycle: at the next edge, j,k return to 0,0 and the state goes to CHECK.
REQ-020 CHECK SHALL last exactly one cycle: at the next edge, the block compares q_fb to the expected value, sets done=1 and match=(q_fb==expected) for one cycle, and returns to IDLE.
REQ-021 Latency SHALL be fixed: done is high in the third cycle after the accept edge.
REQ-022 Throughput SHALL be one command per 3 cycles; a command presented while done=1 is accepted at that edge.
REQ-023 match SHALL hold its last value when done=0.
REQ-024 A mismatch at the CHECK edge SHALL set err=1; err SHALL stay set until err_clr or reset.
REQ-025 If err_clr and a mismatch occur at the same edge, the mismatch SHALL win: err=1 and err_cnt=1.
REQ-026 err_cnt SHALL increment by 1 per mismatch and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 err_clr in any state SHALL NOT affect the FSM, j, k, done or match.
REQ-028 Outside DRIVE, j and k SHALL be 0.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, j=0, k=0, done=0, match=0, err=0, err_cnt=0 and the expected-value register to 0, including mid-operation.
REQ-030 An in-flight command aborted by reset SHALL produce no done pulse.
REQ-031 cmd_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-032 With macro JK_DRIVER_ERRCNT_EN defined, err_cnt SHALL behave per REQ-026.
REQ-033 Without JK_DRIVER_ERRCNT_EN, err_cnt SHALL be constant 0, no counter register SHALL exist, and err SHALL still function.

Verification
REQ-034 Reset sequence: hold reset through 12 time units, then release -> j=k=0, done=0, err=0, cmd_ready=1 on the next cycle.
REQ-035 SET with q_fb=0: after accept, j=1,k=0 for exactly one cycle; flip-flop model gives q_fb=1 -> done=1 and match=1 in the third cycle; err stays 0.
REQ-036 Four back-to-back TOGGLE commands starting from q=0: q_fb follows 1,0,1,0 -> four done pulses spaced 3 cycles apart, all with match=1.
REQ-037 Fault injection: CLR command with q_fb forced stuck at 1 -> match=0, err=1, err_cnt=1; then pulse err_clr -> err=0, err_cnt=0.
REQ-038 With CNT_W=2 and JK_DRIVER_ERRCNT_EN defined, 5 mismatches -> err_cnt=3 (saturated); undefined -> err_cnt=0 and err=1.
REQ-039 Reset asserted during DRIVE: j,k fall to 0 immediately and no done pulse occurs; a HOLD command after release completes with match=1.
